// File: rtl/stream_utils_pkg.sv
// Shared helpers for the stream arbiter: width functions and FSM state encoding.
package stream_utils_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index width, kept at one bit minimum so single-requester builds still have a port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int b);
    return (b > 0) ? $clog2(b + 1) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request starting at ptr, wrapping modulo N.
module rr_pick
  import stream_utils_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW:0] cand;

  // ptr < N and i < N, so one conditional subtract replaces a modulo.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!any && req[cand[IDW-1:0]]) begin
        any = 1'b1;
        idx = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered stream output between NUM_IN requesters,
// holding each grant for a packet or until the burst cap forces a release.
module stream_rr_arbiter
  import stream_utils_pkg::*;
#(
  parameter  int NUM_IN    = 4,
  parameter  int DW        = 32,
  parameter  int BURST_LEN = 16,
  localparam int IDW       = id_width(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN*DW-1:0] s_data_i,
  input  logic [NUM_IN-1:0]    s_last_i,
  input  logic [NUM_IN-1:0]    s_valid_i,
  output logic [NUM_IN-1:0]    s_ready_o,
  output logic [DW-1:0]        m_data_o,
  output logic                 m_last_o,
  output logic [IDW-1:0]       m_id_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 busy_o
);

  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0]  BURST_LAST = (BURST_LEN > 0) ? CW'(BURST_LEN - 1) : '0;
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_IN - 1);

  arb_state_t     state, state_d;
  logic [IDW-1:0] gnt, gnt_d;
  logic [IDW-1:0] ptr, ptr_d;
  logic [IDW-1:0] pick_idx;
  logic [CW-1:0]  beat_cnt, beat_cnt_d;
  logic           pick_any;
  logic           slot_free;
  logic           xfer;
  logic           burst_done;
  logic           release_now;
  logic [DW-1:0]  cur_data;
  logic           cur_last;

  rr_pick #(
    .N   (NUM_IN),
    .IDW (IDW)
  ) u_pick (
    .req (s_valid_i),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign slot_free   = !m_valid_o || m_ready_i;
  assign busy_o      = (state == ST_GRANT);
  assign cur_data    = s_data_i[gnt*DW +: DW];
  assign cur_last    = s_last_i[gnt];
  assign xfer        = busy_o && s_valid_i[gnt] && slot_free;
  assign burst_done  = (BURST_LEN != 0) && (beat_cnt == BURST_LAST);
  assign release_now = xfer && (cur_last || burst_done);

  // Ready never looks at s_valid_i, so there is no valid-to-ready combinational path.
  always_comb begin
    s_ready_o = '0;
    if (busy_o) s_ready_o[gnt] = slot_free;
  end

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    ptr_d      = ptr;
    beat_cnt_d = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (xfer && (BURST_LEN != 0)) beat_cnt_d = beat_cnt + 1'b1;
        if (release_now) begin
          state_d    = ST_IDLE;
          ptr_d      = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
          beat_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      ptr      <= ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  // A forced burst release is flagged as last so downstream sees a closed burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
      m_id_o    <= '0;
    end else if (slot_free) begin
      m_valid_o <= xfer;
      if (xfer) begin
        m_data_o <= cur_data;
        m_last_o <= cur_last || burst_done;
        m_id_o   <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: source queues drive requesters, a scoreboard
// queue holds the beats expected at the output in order.
module tb_stream_rr_arbiter;

  localparam int NUM_IN = 4;
  localparam int DW     = 32;
  localparam int IDW    = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } src_beat_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic           last;
    logic [IDW-1:0] id;
  } exp_beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_IN*DW-1:0] s_data;
  logic [NUM_IN-1:0]    s_last, s_valid;
  logic                 m_ready;
  logic                 sel_b;

  logic [NUM_IN-1:0] a_valid, a_ready;
  logic [DW-1:0]     m_data;
  logic              m_last, m_valid, busy;
  logic [IDW-1:0]    m_id;

  logic [NUM_IN-1:0] b_valid, b_ready;
  logic [DW-1:0]     b_m_data;
  logic              b_m_last, b_m_valid, b_busy;
  logic [IDW-1:0]    b_m_id;

  assign a_valid = sel_b ? '0 : s_valid;
  assign b_valid = sel_b ? s_valid : '0;

  stream_rr_arbiter #(.NUM_IN(NUM_IN), .DW(DW), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(a_valid), .s_ready_o(a_ready),
    .m_data_o(m_data), .m_last_o(m_last), .m_id_o(m_id), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .busy_o(busy)
  );

  stream_rr_arbiter #(.NUM_IN(NUM_IN), .DW(DW), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst(rst),
    .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(b_valid), .s_ready_o(b_ready),
    .m_data_o(b_m_data), .m_last_o(b_m_last), .m_id_o(b_m_id), .m_valid_o(b_m_valid),
    .m_ready_i(m_ready), .busy_o(b_busy)
  );

  logic [NUM_IN-1:0] o_ready;
  logic [DW-1:0]     o_data;
  logic              o_last, o_valid;
  logic [IDW-1:0]    o_id;
  assign o_ready = sel_b ? b_ready   : a_ready;
  assign o_data  = sel_b ? b_m_data  : m_data;
  assign o_last  = sel_b ? b_m_last  : m_last;
  assign o_valid = sel_b ? b_m_valid : m_valid;
  assign o_id    = sel_b ? b_m_id    : m_id;

  src_beat_t         src_q[NUM_IN][$];
  exp_beat_t         exp_q[$];
  logic [NUM_IN-1:0] hs = '0;
  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  int                first_pop_cyc = -1;
  int                last_pop_cyc = -1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    vectors++;
    assert (obs === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expected);
    end
  endtask

  task automatic applyStimulus(input int stream, input logic [DW-1:0] data, input logic last);
    src_beat_t b;
    b.data = data;
    b.last = last;
    src_q[stream].push_back(b);
  endtask

  task automatic expectBeat(input logic [DW-1:0] data, input logic last, input logic [IDW-1:0] id);
    exp_beat_t e;
    e.data = data;
    e.last = last;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  function automatic bit srcEmpty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clearAll();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitDrain(input string tag, input int max_cycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0) && srcEmpty();
      n++;
    end
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("[TB] FAIL %s_drain: observed %0d beats pending, expected 0", tag, exp_q.size());
    end
  endtask

  // Requester model: pops a beat after each handshake, presents the queue head.
  initial begin
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_IN; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          s_valid[i]         = 1'b1;
          s_data[i*DW +: DW] = src_q[i][0].data;
          s_last[i]          = src_q[i][0].last;
        end else begin
          s_valid[i]         = 1'b0;
          s_data[i*DW +: DW] = '0;
          s_last[i]          = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard compare on each output handshake, hold check on stalls.
  initial begin
    exp_beat_t     e;
    logic          stall;
    logic [DW-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      hs = s_valid & o_ready;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) checkOutput("hold", 64'({o_valid, o_data}), 64'({1'b1, held}));
        if (o_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL extra_beat: observed data %0h id %0d, expected no beat", o_data, o_id);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat", 64'({o_id, o_last, o_data}), 64'({e.id, e.last, e.data}));
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
          end
        end
        stall = o_valid && !m_ready;
        held  = o_data;
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b1;
    m_ready = 1'b1;
    sel_b   = 1'b0;

    // Reset held with every requester valid
    for (int i = 0; i < NUM_IN; i++) applyStimulus(i, 32'(32'hF0 + i), 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset", 64'({a_ready, m_valid, m_last, busy, m_id, m_data, b_m_valid, b_busy}), 64'd0);
    end
    step();
    clearAll();
    step();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle", 64'({busy, m_valid, a_ready}), 64'd0);

    // Round robin: 2-beat packets, stream 0 has two packets -> order 0,1,2,3,0
    step();
    first_pop_cyc = -1;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 2; b++) begin
        applyStimulus(p % NUM_IN, 32'(p * 16 + b), b == 1);
        expectBeat(32'(p * 16 + b), b == 1, IDW'(p % NUM_IN));
      end
    end
    waitDrain("rr", 60);
    checkOutput("rr_spacing", 64'(last_pop_cyc - first_pop_cyc), 64'd13);

    // Single requester: stream 2, five beats, last on the fifth
    step();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2, 32'(32'hA0 + k), k == 4);
      expectBeat(32'(32'hA0 + k), k == 4, 2'd2);
    end
    repeat (3) @(negedge clk);
    checkOutput("latency_grant", 64'({m_valid, busy}), 64'(2'b01));
    @(negedge clk);
    checkOutput("latency_out", 64'({m_valid, m_id}), 64'({1'b1, 2'd2}));
    waitDrain("single", 30);

    // Burst cap of 4 on dut_b: stream 1 sends 10 beats with no last, stream 2 waits
    step();
    sel_b = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(1, 32'(32'hB100 + k), 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus(2, 32'(32'hB200 + k), k == 1);
    for (int k = 0; k < 4; k++) expectBeat(32'(32'hB100 + k), k == 3, 2'd1);
    for (int k = 0; k < 2; k++) expectBeat(32'(32'hB200 + k), k == 1, 2'd2);
    for (int k = 4; k < 10; k++) expectBeat(32'(32'hB100 + k), k == 7, 2'd1);
    waitDrain("burst", 60);
    step();
    sel_b = 1'b0;

    // Backpressure: m_ready toggles 1,0,1,0 during a 6-beat packet from stream 1
    step();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 32'(32'hC0 + k), k == 5);
      expectBeat(32'(32'hC0 + k), k == 5, 2'd1);
    end
    n = 0;
    while ((exp_q.size() > 0 || !srcEmpty()) && n < 100) begin
      step();
      m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    waitDrain("backpressure", 20);

    // Reset mid-packet: stream 3 sends 8 beats, reset after the third leaves
    step();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3, 32'(32'hD0 + k), k == 7);
      expectBeat(32'(32'hD0 + k), k == 7, 2'd3);
    end
    n = 0;
    while (exp_q.size() > 5 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    assert (exp_q.size() <= 5) else begin
      miscompares++;
      $error("[TB] FAIL mid_beats: observed %0d beats pending, expected 5", exp_q.size());
    end
    step();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_mid", 64'({m_valid, busy, a_ready}), 64'd0);
    step();
    clearAll();
    applyStimulus(3, 32'hE3, 1'b1);
    applyStimulus(0, 32'hE0, 1'b1);
    expectBeat(32'hE0, 1'b1, 2'd0);
    expectBeat(32'hE3, 1'b1, 2'd3);
    step();
    rst = 1'b0;
    waitDrain("post_reset", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
